// File: rtl/gf180mcu_nandn_pkg.sv
// Shared sizing helpers and mode encoding for the pipelined NAND/NOR reduction tree.
// The tree depth is the number of FANIN-wide AND levels needed to cover WIDTH inputs.
package gf180mcu_nandn_pkg;

  localparam logic MODE_NAND = 1'b0;
  localparam logic MODE_NOR  = 1'b1;

  function automatic int fanin_pow(input int fanin, input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * fanin;
    return p;
  endfunction

  // Levels of FANIN-input nodes needed to reduce WIDTH bits to one; never below 1.
  function automatic int clog_fanin(input int width, input int fanin);
    int lv;
    int cap;
    lv  = 0;
    cap = 1;
    while (cap < width) begin
      cap = cap * fanin;
      lv  = lv + 1;
    end
    return (lv < 1) ? 1 : lv;
  endfunction

  function automatic int pad_width(input int width, input int fanin);
    return fanin_pow(fanin, clog_fanin(width, fanin));
  endfunction

  // Bit count entering tree level lvl (level 0 is the padded operand).
  function automatic int level_width(input int width, input int fanin, input int lvl);
    return pad_width(width, fanin) / fanin_pow(fanin, lvl);
  endfunction

  // Offset of level lvl inside the flattened vector that holds every level back to back.
  function automatic int level_off(input int width, input int fanin, input int lvl);
    int off;
    off = 0;
    for (int j = 0; j < lvl; j++) off = off + level_width(width, fanin, j);
    return off;
  endfunction

endpackage

// File: rtl/gf180mcu_nandn_stage.sv
// One registered level of the AND reduction tree: IN_W bits reduce to IN_W/FANIN bits,
// with the beat's valid and mode bits travelling alongside.
module gf180mcu_nandn_stage
  import gf180mcu_nandn_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int FANIN = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic [IN_W-1:0]           D,
  output logic [IN_W/FANIN-1:0]     Q,
  input  logic                      VLD_I,
  output logic                      VLD_O,
  input  logic                      MODE_I,
  output logic                      MODE_O
);

  localparam int OUT_W = IN_W / FANIN;

  logic [OUT_W-1:0] grp;

  always_comb begin
    grp = '0;
    for (int g = 0; g < OUT_W; g++) begin
      grp[g] = &D[g*FANIN +: FANIN];
    end
  end

  // Data loads regardless of valid; bubbles just carry VLD=0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q      <= '0;
      VLD_O  <= 1'b0;
      MODE_O <= MODE_NAND;
    end else if (EN) begin
      Q      <= grp;
      VLD_O  <= VLD_I;
      MODE_O <= MODE_I;
    end
  end

endmodule

// File: rtl/gf180mcu_nandn_pipe.sv
// Pipelined WIDTH-input NAND/NOR detector built from LAT registered FANIN-input AND levels.
// Optional sticky zero-result flag enabled by defining GF180MCU_NANDN_STICKY_EN.
module gf180mcu_nandn_pipe
  import gf180mcu_nandn_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FANIN = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             VLD_I,
  input  logic             MODE,
  input  logic [WIDTH-1:0] A,
  output logic             ZN,
  output logic             VLD_O,
  input  logic             CLR_STICKY,
  output logic             STICKY
);

  localparam int LAT   = clog_fanin(WIDTH, FANIN);
  localparam int PAD_W = pad_width(WIDTH, FANIN);
  localparam int TOT_W = level_off(WIDTH, FANIN, LAT) + 1;

  // Beat protocol: a beat is taken on every edge with EN=1 (VLD_I marks it real);
  // VLD_O qualifies ZN and must be sampled on every EN=1 cycle, there is no backpressure.

  logic [PAD_W-1:0] operand;
  logic [TOT_W-1:0] tree;
  logic [LAT:0]     vld_chain;
  logic [LAT:0]     mode_chain;

  // NOR is an AND over the inverted operand; padding uses the AND identity.
  always_comb begin
    operand = '1;
    operand[WIDTH-1:0] = (MODE == MODE_NOR) ? ~A : A;
  end

  assign tree[PAD_W-1:0] = operand;
  assign vld_chain[0]    = VLD_I;
  assign mode_chain[0]   = MODE;

  for (genvar l = 0; l < LAT; l++) begin : g_level
    localparam int IN_W  = level_width(WIDTH, FANIN, l);
    localparam int OUT_W = level_width(WIDTH, FANIN, l + 1);
    localparam int IN_O  = level_off(WIDTH, FANIN, l);
    localparam int OUT_O = level_off(WIDTH, FANIN, l + 1);

    gf180mcu_nandn_stage #(
      .IN_W  (IN_W),
      .FANIN (FANIN)
    ) u_stage (
      .CLK    (CLK),
      .RST    (RST),
      .EN     (EN),
      .D      (tree[IN_O +: IN_W]),
      .Q      (tree[OUT_O +: OUT_W]),
      .VLD_I  (vld_chain[l]),
      .VLD_O  (vld_chain[l+1]),
      .MODE_I (mode_chain[l]),
      .MODE_O (mode_chain[l+1])
    );
  end

  // NAND inverts the final AND; NOR (already inverted at the input) passes it through.
  // Reset leaves AND=0 and mode=NAND, so ZN comes out of reset as 1.
  assign ZN    = ~(tree[TOT_W-1] ^ mode_chain[LAT]);
  assign VLD_O = vld_chain[LAT];

`ifdef GF180MCU_NANDN_STICKY_EN
  localparam int LAST_O = level_off(WIDTH, FANIN, LAT - 1);

  logic next_and;
  logic sticky_set;
  logic sticky_q;

  // Look at what the output register is about to load so the flag rises with VLD_O.
  assign next_and   = &tree[LAST_O +: FANIN];
  assign sticky_set = EN & vld_chain[LAT-1] & (next_and ^ mode_chain[LAT-1]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sticky_q <= 1'b0;
    end else if (sticky_set) begin
      sticky_q <= 1'b1;
    end else if (CLR_STICKY) begin
      sticky_q <= 1'b0;
    end
  end

  assign STICKY = sticky_q;
`else
  logic unused_clr_sticky;

  assign unused_clr_sticky = CLR_STICKY;
  assign STICKY            = 1'b0;
`endif

endmodule

// File: tb/tb_gf180mcu_nandn_pipe.sv
// Directed bench for gf180mcu_nandn_pipe: reset, NAND/NOR beats, stall, padding and sticky flag.
module tb_gf180mcu_nandn_pipe;

`ifdef GF180MCU_NANDN_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic        VLD_I;
  logic        MODE;
  logic [15:0] A;
  logic        CLR_STICKY;
  logic        ZN, VLD_O, STICKY;

  logic        VLD_I5, MODE5;
  logic [4:0]  A5;
  logic        ZN5, VLD_O5, STICKY5;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  gf180mcu_nandn_pipe #(.WIDTH(16), .FANIN(4)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .VLD_I(VLD_I), .MODE(MODE), .A(A),
    .ZN(ZN), .VLD_O(VLD_O), .CLR_STICKY(CLR_STICKY), .STICKY(STICKY)
  );

  gf180mcu_nandn_pipe #(.WIDTH(5), .FANIN(4)) dut5 (
    .CLK(CLK), .RST(RST), .EN(EN), .VLD_I(VLD_I5), .MODE(MODE5), .A(A5),
    .ZN(ZN5), .VLD_O(VLD_O5), .CLR_STICKY(CLR_STICKY), .STICKY(STICKY5)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Main stream: mode, operand, hand-computed ZN
  logic [15:0] ba [10];
  logic        bm [10];
  logic        bz [10];
  // Stall stream
  logic [15:0] sa [6];
  logic        sm [6];
  logic        sz [6];
  // Padding stream (WIDTH=5)
  logic [4:0]  pa [4];
  logic        pm [4];
  logic        pz [4];

  initial begin
    ba = '{16'hFFFF, 16'hFFFE, 16'h0000, 16'h0001, 16'hFFFF,
           16'h0000, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    bm = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bz = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    sa = '{16'hFFFF, 16'h0000, 16'h1234, 16'h0100, 16'hFFFF, 16'h0000};
    sm = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    sz = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    pa = '{5'h1F, 5'h0F, 5'h00, 5'h10};
    pm = '{1'b0, 1'b0, 1'b1, 1'b1};
    pz = '{1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held with an all-ones beat pending
    RST = 1'b1; EN = 1'b1; VLD_I = 1'b1; MODE = 1'b0; A = 16'hFFFF; CLR_STICKY = 1'b0;
    VLD_I5 = 1'b0; MODE5 = 1'b0; A5 = 5'h1F;
    #2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_zn", ZN, 1'b1);
      chk("rst_vld", VLD_O, 1'b0);
      chk("rst_sticky", STICKY, 1'b0);
      chk("rst_zn5", ZN5, 1'b1);
    end
    RST = 1'b0;
    tick();
    chk("rel_vld_1", VLD_O, 1'b0);
    tick();
    chk("rel_vld_2", VLD_O, 1'b1);
    chk("rel_zn_2", ZN, 1'b0);
    chk("rel_sticky", STICKY, STK);

    // Back-to-back beats, interleaved modes
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        VLD_I = 1'b1; MODE = bm[i]; A = ba[i];
      end else begin
        VLD_I = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk($sformatf("main_vld_%0d", i - 1), VLD_O, 1'b1);
        chk($sformatf("main_zn_%0d", i - 1), ZN, bz[i-1]);
      end
    end
    tick();
    chk("main_bubble", VLD_O, 1'b0);

    // Stall: three EN=0 cycles after beat 2 enters
    for (int i = 0; i < 3; i++) begin
      VLD_I = 1'b1; MODE = sm[i]; A = sa[i];
      tick();
      if (i == 0) chk("stall_pre", VLD_O, 1'b0);
      else begin
        chk($sformatf("stall_vld_%0d", i - 1), VLD_O, 1'b1);
        chk($sformatf("stall_zn_%0d", i - 1), ZN, sz[i-1]);
      end
    end
    EN = 1'b0; VLD_I = 1'b1; MODE = 1'b0; A = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_vld", VLD_O, 1'b1);
      chk("stall_hold_zn", ZN, sz[1]);
    end
    EN = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      if (i < 6) begin
        VLD_I = 1'b1; MODE = sm[i]; A = sa[i];
      end else begin
        VLD_I = 1'b0;
      end
      tick();
      chk($sformatf("stall_vld_%0d", i - 1), VLD_O, 1'b1);
      chk($sformatf("stall_zn_%0d", i - 1), ZN, sz[i-1]);
    end
    tick();
    chk("stall_bubble", VLD_O, 1'b0);

    // Sticky flag
    CLR_STICKY = 1'b1;
    tick();
    chk("stk_clr0", STICKY, 1'b0);
    CLR_STICKY = 1'b0; VLD_I = 1'b1; MODE = 1'b0; A = 16'hFFFF;
    tick();
    chk("stk_early", STICKY, 1'b0);
    VLD_I = 1'b0;
    tick();
    chk("stk_set_vld", VLD_O, 1'b1);
    chk("stk_set_zn", ZN, 1'b0);
    chk("stk_set", STICKY, STK);
    CLR_STICKY = 1'b1;
    tick();
    chk("stk_clr1", STICKY, 1'b0);
    CLR_STICKY = 1'b0; VLD_I = 1'b1; A = 16'hFFFF;
    tick();
    VLD_I = 1'b0; CLR_STICKY = 1'b1;
    tick();
    chk("stk_set_wins", STICKY, STK);
    chk("stk_set_wins_vld", VLD_O, 1'b1);
    CLR_STICKY = 1'b0; EN = 1'b0;
    tick();
    chk("stk_hold_en0", STICKY, STK);
    CLR_STICKY = 1'b1;
    tick();
    chk("stk_clr_en0", STICKY, 1'b0);
    chk("stk_clr_en0_vld", VLD_O, 1'b1);
    CLR_STICKY = 1'b0; EN = 1'b1;

    // Padding, WIDTH=5
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        VLD_I5 = 1'b1; MODE5 = pm[i]; A5 = pa[i];
      end else begin
        VLD_I5 = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk($sformatf("pad_vld_%0d", i - 1), VLD_O5, 1'b1);
        chk($sformatf("pad_zn_%0d", i - 1), ZN5, pz[i-1]);
      end
    end
    tick();
    chk("pad_bubble", VLD_O5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
